// File: rtl/branch_update_queue.sv
// branch_update_queue
//
// In-order queue of predicted conditional branches sitting between fetch and
// resolution. Each resolution produces a one-cycle registered update for the
// gshare direction predictor. A mispredicting resolution flushes every younger
// (wrong-path) entry.
//
// Ports:
//   clk            clock, all state changes on the rising edge
//   reset          synchronous, active-low reset
//   enq_val/rdy    fetch handshake; enq_pc/enq_pred give the predicted branch
//   res_val/rdy    resolve handshake for the oldest entry; res_taken is its outcome
//   upd_en         one-cycle predictor update strobe, with upd_val (outcome) and upd_pc
//   mispred        one-cycle pulse, aligned with upd_en, when the prediction was wrong
//   count          current occupancy
//   stat_resolved  resolutions since reset (wraps)
//   stat_mispred   mispredictions since reset (wraps)

module branch_update_queue #(
    parameter int DEPTH = 8,
    parameter int CNT_W = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       enq_val,
    output logic                       enq_rdy,
    input  logic [31:0]                enq_pc,
    input  logic                       enq_pred,
    input  logic                       res_val,
    output logic                       res_rdy,
    input  logic                       res_taken,
    output logic                       upd_en,
    output logic                       upd_val,
    output logic [31:0]                upd_pc,
    output logic                       mispred,
    output logic [$clog2(DEPTH):0]     count,
    output logic [CNT_W-1:0]           stat_resolved,
    output logic [CNT_W-1:0]           stat_mispred
);

    localparam int PTR_W    = $clog2(DEPTH);
    localparam int CNT_BITS = PTR_W + 1;
    localparam logic [CNT_BITS-1:0] FULL_CNT = CNT_BITS'(DEPTH);

    logic [31:0]         pc_mem   [DEPTH];
    logic                pred_mem [DEPTH];

    logic [PTR_W-1:0]    head;
    logic [PTR_W-1:0]    tail;
    logic [CNT_BITS-1:0] occ;

    logic                enq_fire;
    logic                res_fire;
    logic                res_miss;

    // Handshake readiness depends on registered occupancy only, so a full
    // queue never takes an entry even if a resolve frees a slot this cycle.
    assign enq_rdy  = (occ < FULL_CNT);
    assign res_rdy  = (occ != '0);
    assign count    = occ;

    assign enq_fire = enq_val && enq_rdy;
    assign res_fire = res_val && res_rdy;
    assign res_miss = res_fire && (pred_mem[head] != res_taken);

    // NOTE: entry storage has no reset; a slot is only ever read after it has
    // been written, and leaving it unreset lets it map onto plain RAM.
    always_ff @(posedge clk) begin
        if (enq_fire) begin
            pc_mem[tail]   <= enq_pc;
            pred_mem[tail] <= enq_pred;
        end
    end

    // Pointers and occupancy.
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge values of its neighbours regardless of statement order.
    always_ff @(posedge clk) begin
        if (!reset) begin
            head <= '0;
            tail <= '0;
            occ  <= '0;
        end else if (res_miss) begin
            // Flush: everything younger is wrong-path, including an entry
            // offered in this same cycle (tail is deliberately not advanced).
            head <= tail;
            occ  <= '0;
        end else begin
            if (enq_fire) begin
                tail <= tail + PTR_W'(1);
            end
            if (res_fire) begin
                head <= head + PTR_W'(1);
            end
            case ({enq_fire, res_fire})
                2'b10:   occ <= occ + CNT_BITS'(1);
                2'b01:   occ <= occ - CNT_BITS'(1);
                default: occ <= occ;
            endcase
        end
    end

    // Registered predictor update, one cycle after the resolve edge.
    always_ff @(posedge clk) begin
        if (!reset) begin
            upd_en  <= 1'b0;
            upd_val <= 1'b0;
            upd_pc  <= '0;
            mispred <= 1'b0;
        end else begin
            upd_en  <= res_fire;
            mispred <= res_miss;
            if (res_fire) begin
                upd_val <= res_taken;
                upd_pc  <= pc_mem[head];
            end
        end
    end

    // Statistics counters; natural wrap at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (!reset) begin
            stat_resolved <= '0;
            stat_mispred  <= '0;
        end else begin
            if (res_fire) begin
                stat_resolved <= stat_resolved + CNT_W'(1);
            end
            if (res_miss) begin
                stat_mispred <= stat_mispred + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_branch_update_queue.sv
// Self-checking bench for branch_update_queue: directed scenarios followed by
// randomized traffic, all checked against a queue-based reference model.
// Expected predictor updates go into a scoreboard; an independent monitor
// compares them whenever the DUT raises upd_en.

module tb_branch_update_queue;

    localparam int DEPTH = 8;
    localparam int CNT_W = 32;
    localparam int CW    = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             reset;
    logic             enq_val;
    logic             enq_rdy;
    logic [31:0]      enq_pc;
    logic             enq_pred;
    logic             res_val;
    logic             res_rdy;
    logic             res_taken;
    logic             upd_en;
    logic             upd_val;
    logic [31:0]      upd_pc;
    logic             mispred;
    logic [CW-1:0]    count;
    logic [CNT_W-1:0] stat_resolved;
    logic [CNT_W-1:0] stat_mispred;

    branch_update_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .enq_val(enq_val), .enq_rdy(enq_rdy), .enq_pc(enq_pc), .enq_pred(enq_pred),
        .res_val(res_val), .res_rdy(res_rdy), .res_taken(res_taken),
        .upd_en(upd_en), .upd_val(upd_val), .upd_pc(upd_pc), .mispred(mispred),
        .count(count), .stat_resolved(stat_resolved), .stat_mispred(stat_mispred)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] pc;
        logic        pred;
    } ent_t;

    typedef struct {
        int          cyc;
        logic [31:0] pc;
        logic        val;
        logic        mis;
    } upd_t;

    ent_t mq[$];          // reference model: branches in flight, oldest first
    upd_t sb[$];          // scoreboard of expected predictor updates
    int   m_resolved = 0;
    int   m_mispred  = 0;

    int   n_tests = 0;
    int   n_fail  = 0;
    int   cyc     = 0;
    bit   mon_on  = 1'b0;

    always @(posedge clk) cyc++;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at cycle %0d: got 0x%0h expected 0x%0h", name, cyc, act, exp);
        end
    endtask

    // Monitor: compares every predictor update against the scoreboard, and
    // catches updates that are missing, late or spurious.
    always @(negedge clk) begin
        if (mon_on) begin
            if (upd_en === 1'b1) begin
                if (sb.size() == 0) begin
                    check("spurious_upd_en", 64'(upd_en), 64'd0);
                end else begin
                    upd_t e;
                    e = sb.pop_front();
                    check("upd_cycle", 64'(cyc), 64'(e.cyc));
                    check("upd_pc", 64'(upd_pc), 64'(e.pc));
                    check("upd_val", 64'(upd_val), 64'(e.val));
                    check("mispred", 64'(mispred), 64'(e.mis));
                end
            end else begin
                check("upd_en_idle", 64'(upd_en), 64'd0);
                check("mispred_idle", 64'(mispred), 64'd0);
                if (sb.size() != 0 && sb[0].cyc <= cyc) begin
                    check("missing_upd", 64'(upd_en), 64'd1);
                    void'(sb.pop_front());
                end
            end
        end
    end

    function automatic logic head_pred();
        return (mq.size() != 0) ? mq[0].pred : 1'b0;
    endfunction

    // One cycle: check architectural state against the model, drive inputs
    // for the coming edge, and advance the model by that edge's rules.
    task automatic step(input logic rst_v, input logic ev, input logic [31:0] pc,
                        input logic pr, input logic rv, input logic tk);
        bit e_fire;
        bit r_fire;
        ent_t h;
        @(negedge clk);
        check("count", 64'(count), 64'(mq.size()));
        check("enq_rdy", 64'(enq_rdy), 64'(mq.size() < DEPTH));
        check("res_rdy", 64'(res_rdy), 64'(mq.size() != 0));
        check("stat_resolved", 64'(stat_resolved), 64'(m_resolved));
        check("stat_mispred", 64'(stat_mispred), 64'(m_mispred));

        reset     = rst_v;
        enq_val   = ev;
        enq_pc    = pc;
        enq_pred  = pr;
        res_val   = rv;
        res_taken = tk;

        if (!rst_v) begin
            mq.delete();
            m_resolved = 0;
            m_mispred  = 0;
        end else begin
            e_fire = ev && (mq.size() < DEPTH);
            r_fire = rv && (mq.size() != 0);
            if (r_fire) begin
                h = mq.pop_front();
                m_resolved++;
                sb.push_back('{cyc: cyc + 1, pc: h.pc, val: tk, mis: (h.pred != tk)});
                if (h.pred != tk) begin
                    m_mispred++;
                    mq.delete();
                    e_fire = 1'b0;
                end
            end
            if (e_fire) mq.push_back('{pc: pc, pred: pr});
        end
    endtask

    task automatic idle();
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic enq(input logic [31:0] pc, input logic pr);
        step(1'b1, 1'b1, pc, pr, 1'b0, 1'b0);
    endtask

    task automatic res(input logic tk);
        step(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, tk);
    endtask

    initial begin
        reset = 1'b0; enq_val = 1'b0; enq_pc = '0; enq_pred = 1'b0;
        res_val = 1'b0; res_taken = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1 mon_on = 1'b1;

        // Basic in-order flow, back-to-back resolves.
        enq(32'h100, 1'b1);
        enq(32'h104, 1'b0);
        enq(32'h108, 1'b1);
        res(1'b1);
        res(1'b0);
        res(1'b1);
        idle();

        // Fill, drop while full, then traffic across the pointer wrap.
        for (int i = 0; i < DEPTH; i++) enq(32'h200 + 32'(4 * i), 1'(i % 2));
        enq(32'hDEAD_BEEC, 1'b1);
        res(head_pred());
        for (int i = 0; i < DEPTH; i++)
            step(1'b1, 1'b1, 32'h300 + 32'(4 * i), 1'(i % 3 == 0), 1'b1, head_pred());
        while (mq.size() != 0) res(head_pred());
        idle();

        // Mispredict flush, then resolves on an empty queue are ignored.
        for (int i = 0; i < 4; i++) enq(32'h400 + 32'(4 * i), 1'b1);
        res(1'b0);
        res(1'b1);
        res(1'b0);
        idle();

        // Simultaneous enqueue + resolve at count 2, correct then wrong.
        enq(32'h500, 1'b1);
        enq(32'h504, 1'b0);
        step(1'b1, 1'b1, 32'h508, 1'b1, 1'b1, 1'b1);
        step(1'b1, 1'b1, 32'h50C, 1'b0, 1'b1, 1'b1);
        idle();

        // Resolve while empty, then reset mid-operation with a resolve pending.
        res(1'b1);
        res(1'b0);
        for (int i = 0; i < 5; i++) enq(32'h600 + 32'(4 * i), 1'(i % 2));
        step(1'b0, 1'b1, 32'h700, 1'b1, 1'b1, head_pred());
        idle();
        idle();

        // Randomized traffic with occasional mispredicts and resets.
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r;
            logic [31:0] p;
            logic        tk;
            r  = $urandom();
            p  = $urandom();
            tk = ($urandom_range(0, 9) < 8) ? head_pred() : ~head_pred();
            step(($urandom_range(0, 299) != 0), r[0] | r[1], {p[31:2], 2'b00},
                 r[2], r[3] & (r[4] | r[5]), tk);
        end

        for (int i = 0; i < 3; i++) idle();
        check("scoreboard_drained", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/branch_update_queue.md
# branch_update_queue

Tracks in-flight conditional branches between fetch and resolution and drives the update port of the gshare direction predictor. Fetch enqueues each predicted branch's PC and predicted direction. The execute stage resolves branches strictly in order. On each resolution the block issues a one-cycle registered update (enable, outcome, PC) to the predictor, flags mispredictions, and flushes all younger entries on a mispredict.

## Interface
Parameters:
- DEPTH, 8, number of queue entries; power of two, ≥ 2
- CNT_W, 32, width of the statistics counters

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low; state is reset on any rising edge where reset == 0
- enq_val  in  1  fetch offers a predicted branch
- enq_rdy  out  1  queue can accept an entry
- enq_pc  in  32  branch PC; bits [1:0] are always 0
- enq_pred  in  1  predicted direction (1 = taken)
- res_val  in  1  oldest branch resolved this cycle
- res_rdy  out  1  queue holds at least one entry
- res_taken  in  1  actual outcome of the oldest branch
- upd_en  out  1  predictor update enable
- upd_val  out  1  predictor update outcome
- upd_pc  out  32  PC the predictor updates with
- mispred  out  1  one-cycle pulse: the resolved branch was mispredicted
- count  out  $clog2(DEPTH)+1  current occupancy
- stat_resolved  out  CNT_W  total resolutions since reset
- stat_mispred  out  CNT_W  total mispredictions since reset

## Operation
- Circular FIFO with head/tail pointers of $clog2(DEPTH) bits plus an occupancy counter. Each entry holds {pc[31:0], pred}.
- enq_rdy = (count < DEPTH). No same-cycle bypass: a full queue does not accept an entry even when a resolve happens in the same cycle.
- res_rdy = (count != 0). A res_val while res_rdy = 0 is ignored and has no effect on any state.
- Enqueue fires when enq_val && enq_rdy. The entry is written at tail, tail increments and wraps modulo DEPTH.
- Resolve fires when res_val && res_rdy. The head entry is read and head increments with wrap. The following are registered for the next cycle:
  - upd_en = 1
  - upd_val = res_taken
  - upd_pc = head.pc
  - mispred = (head.pred != res_taken)
- Mispredict flush: when a fired resolve mismatches, all remaining entries are discarded in the same edge. Head is set equal to tail and count becomes 0.
- Simultaneous enqueue and resolve:
  - Without mispredict: both take effect and count is unchanged.
  - With mispredict: the flush wins, the enqueued entry is dropped as wrong-path, and count = 0.
- Statistics:
  - stat_resolved increments on every fired resolve.
  - stat_mispred increments on every fired mispredicting resolve.
  - Both wrap modulo 2^CNT_W.

## Timing
- Reset values: enq_rdy = 1, res_rdy = 0, upd_en = 0, upd_val = 0, upd_pc = 0, mispred = 0, count = 0, both stats = 0, pointers = 0. Entry contents are don't-care.
- Reset takes priority over any simultaneous enqueue or resolve. Reset asserted mid-operation discards all entries and any pending update. upd_en is 0 in the cycle after that edge.
- Latency is 1 cycle: a resolve fired at edge N drives upd_en/upd_val/upd_pc/mispred during cycle N+1. These signals are high for exactly one cycle per fired resolve.
- Back-to-back resolves give upd_en high on consecutive cycles.
- enq_rdy, res_rdy and count are combinational from registered state only. They do not depend on same-cycle inputs.
- An entry enqueued at edge N is resolvable from cycle N+1 (res_rdy = 1).
- Pointer wrap is invisible externally: FIFO order is preserved across wrap.

## Test plan
- Reset, then 3 enqueues (PC 0x100/T, 0x104/N, 0x108/T) and 3 matching resolves -> upd_pc 0x100, 0x104, 0x108 on consecutive cycles with upd_val 1, 0, 1; mispred never 1; stat_resolved = 3, stat_mispred = 0.
- Fill with DEPTH = 8 entries -> enq_rdy = 0 and count = 8; an enq_val while full is dropped. Resolve one -> enq_rdy = 1 next cycle. Then enqueue 8 more across the wrap boundary; FIFO order is preserved.
- Enqueue 4 entries; resolve the first with the opposite direction -> mispred = 1 for one cycle and count = 0 next cycle; later res_val is ignored; stat_mispred = 1.
- Same-cycle enqueue and resolve with count = 2: a correct resolve leaves count = 2; a mispredicting resolve gives count = 0 and the new entry is absent.
- res_val while empty -> no upd_en, stats unchanged. Assert reset (0) with 5 entries queued and a resolve pending -> next cycle count = 0, upd_en = 0, stats = 0.
